// File: rtl/axi_lite_ram_bridge.sv
// AXI4-Lite (64-bit) slave that turns AR/R and AW/W/B handshakes into single-cycle,
// stable access strobes for a combinational DPI-backed RAM controller.
module axi_lite_ram_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter bit ALIGN      = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // AXI4-Lite write address / data / response
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [63:0]           s_wdata,
  input  logic [7:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  // AXI4-Lite read address / data
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [63:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  // RAM controller side
  output logic [63:0]           ram_raddr,
  input  logic [63:0]           ram_rdata,
  output logic                  ram_rflag,
  output logic [63:0]           ram_waddr,
  output logic [63:0]           ram_wdata,
  output logic [63:0]           ram_wmask,
  output logic                  ram_wen,
  // FSM state for debug/checkers
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACC  = 3'd1,
    WR_RESP = 3'd2,
    RD_ACC  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t                state_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [63:0]           wdata_q;
  logic [7:0]            wstrb_q;
  logic [63:0]           rdata_q;
  logic                  bvalid_q, rvalid_q;
  logic                  ram_wen_q, ram_rflag_q;
  logic [63:0]           ram_raddr_q, ram_waddr_q, ram_wdata_q, ram_wmask_q;

  logic                  is_idle;
  logic                  aw_hs, w_hs, ar_hs, write_go;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [63:0]           wdata_d;
  logic [7:0]            wstrb_d;

  function automatic logic [63:0] map_addr(input logic [ADDR_WIDTH-1:0] a);
    logic [63:0] r;
    r                 = '0;
    r[ADDR_WIDTH-1:0] = a;
    if (ALIGN) r[2:0] = 3'b000;
    return r;
  endfunction

  function automatic logic [63:0] expand_mask(input logic [7:0] strb);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

  // Valid/ready: a beat transfers on a rising edge where valid && ready. Valids here are
  // registered and stay high until taken; readys are only offered in IDLE and are gated
  // by reset_n so nothing is accepted while reset is asserted. Reads are refused while a
  // write is pending or arriving, which gives writes priority.
  assign is_idle   = (state_q == IDLE);
  assign s_awready = reset_n & is_idle & ~aw_held_q;
  assign s_wready  = reset_n & is_idle & ~w_held_q;
  assign s_arready = reset_n & is_idle & ~aw_held_q & ~w_held_q & ~s_awvalid & ~s_wvalid;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  // The last of AW/W may land in the same cycle as the transition, so take it directly.
  assign write_go = is_idle & (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign waddr_d  = aw_hs ? s_awaddr : addr_q;
  assign wdata_d  = w_hs ? s_wdata : wdata_q;
  assign wstrb_d  = w_hs ? s_wstrb : wstrb_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_rflag_q <= 1'b0;
      ram_raddr_q <= '0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      ram_wmask_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_hs) begin
            addr_q    <= s_awaddr;
            aw_held_q <= 1'b1;
          end
          if (w_hs) begin
            wdata_q  <= s_wdata;
            wstrb_q  <= s_wstrb;
            w_held_q <= 1'b1;
          end
          if (write_go) begin
            state_q     <= WR_ACC;
            ram_wen_q   <= 1'b1;
            ram_waddr_q <= map_addr(waddr_d);
            ram_wdata_q <= wdata_d;
            ram_wmask_q <= expand_mask(wstrb_d);
          end else if (ar_hs) begin
            state_q     <= RD_ACC;
            addr_q      <= s_araddr;
            ram_rflag_q <= 1'b1;
            ram_raddr_q <= map_addr(s_araddr);
          end
        end
        WR_ACC: begin
          ram_wen_q <= 1'b0;
          aw_held_q <= 1'b0;
          w_held_q  <= 1'b0;
          bvalid_q  <= 1'b1;
          state_q   <= WR_RESP;
        end
        WR_RESP: begin
          if (s_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RD_ACC: begin
          // RAM data is combinational on ram_raddr; capture it while rflag is high.
          ram_rflag_q <= 1'b0;
          rdata_q     <= ram_rdata;
          rvalid_q    <= 1'b1;
          state_q     <= RD_RESP;
        end
        RD_RESP: begin
          if (s_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_bresp     = 2'b00;
  assign s_bvalid    = bvalid_q;
  assign s_rresp     = 2'b00;
  assign s_rvalid    = rvalid_q;
  assign s_rdata     = rdata_q;
  assign ram_raddr   = ram_raddr_q;
  assign ram_rflag   = ram_rflag_q;
  assign ram_waddr   = ram_waddr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_wmask   = ram_wmask_q;
  assign ram_wen     = ram_wen_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_lite_ram_bridge.sv
// Directed bench for axi_lite_ram_bridge: an ALIGN=1 instance against a RAM model and
// reference memory, plus an ALIGN=0 instance sharing the stimulus for address pass-through.
module tb_axi_lite_ram_bridge;

  logic        clock;
  logic        reset_n;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [63:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata, ram_wmask;
  logic        ram_rflag, ram_wen;
  logic [2:0]  dbg_state;

  logic        a0_awready, a0_wready, a0_bvalid, a0_arready, a0_rvalid, a0_rflag, a0_wen;
  logic [1:0]  a0_bresp, a0_rresp;
  logic [63:0] a0_rdata, a0_raddr, a0_ram_rdata, a0_waddr, a0_wdata, a0_wmask;
  logic [2:0]  a0_state;

  logic [63:0] mem     [32];
  logic [63:0] ref_mem [32];
  logic [63:0] exp_q[$];
  int          errors, checks;
  int          wen_cnt, rflag_cnt;

  axi_lite_ram_bridge #(.ADDR_WIDTH(32), .ALIGN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_rflag(ram_rflag),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen),
    .dbg_state_o(dbg_state)
  );

  axi_lite_ram_bridge #(.ADDR_WIDTH(32), .ALIGN(1'b0)) dut_a0 (
    .clock(clock), .reset_n(reset_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(a0_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(a0_wready),
    .s_bresp(a0_bresp), .s_bvalid(a0_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(a0_arready),
    .s_rdata(a0_rdata), .s_rresp(a0_rresp), .s_rvalid(a0_rvalid), .s_rready(s_rready),
    .ram_raddr(a0_raddr), .ram_rdata(a0_ram_rdata), .ram_rflag(a0_rflag),
    .ram_waddr(a0_waddr), .ram_wdata(a0_wdata), .ram_wmask(a0_wmask), .ram_wen(a0_wen),
    .dbg_state_o(a0_state)
  );

  // ---------------- clock / RAM model / pulse counters ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ram_rdata    = mem[ram_raddr[7:3]];
  assign a0_ram_rdata = mem[a0_raddr[7:3]];

  always @(posedge clock) begin
    if (ram_wen === 1'b1)
      mem[ram_waddr[7:3]] <= (mem[ram_waddr[7:3]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    if (ram_wen === 1'b1)   wen_cnt   <= wen_cnt + 1;
    if (ram_rflag === 1'b1) rflag_cnt <= rflag_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drv_read(input logic [31:0] a, output logic [63:0] d, output bit to);
    int n;
    int k;
    bit done;
    to = 1'b0; d = '0; done = 1'b0; n = 0;
    s_araddr = a; s_arvalid = 1'b1;
    while (!done && n < 50) begin
      #1; done = s_arready;
      @(posedge clock); #1; n++;
    end
    s_arvalid = 1'b0;
    if (!done) begin to = 1'b1; return; end
    n = 0;
    while (s_rvalid !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    if (s_rvalid !== 1'b1) begin to = 1'b1; return; end
    d = s_rdata;
    k = $urandom_range(0, 2);
    repeat (k) begin @(posedge clock); #1; end
    s_rready = 1'b1;
    @(posedge clock); #1;
    s_rready = 1'b0;
  endtask

  task automatic drv_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           output bit to);
    int n;
    int k;
    int ord;
    bit aw_done, w_done;
    logic raw, rw;
    to = 1'b0; aw_done = 1'b0; w_done = 1'b0; n = 0;
    ord = $urandom_range(0, 2);
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    s_awvalid = (ord != 1);
    s_wvalid  = (ord != 2);
    while (!(aw_done && w_done) && n < 50) begin
      #1; raw = s_awready & s_awvalid; rw = s_wready & s_wvalid;
      @(posedge clock); #1; n++;
      if (raw) begin aw_done = 1'b1; s_awvalid = 1'b0; end
      if (rw)  begin w_done  = 1'b1; s_wvalid  = 1'b0; end
      if (!aw_done) s_awvalid = 1'b1;
      if (!w_done)  s_wvalid  = 1'b1;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (!(aw_done && w_done)) begin to = 1'b1; return; end
    n = 0;
    while (s_bvalid !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    if (s_bvalid !== 1'b1) begin to = 1'b1; return; end
    k = $urandom_range(0, 2);
    repeat (k) begin @(posedge clock); #1; end
    s_bready = 1'b1;
    @(posedge clock); #1;
    s_bready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1;
    checks++; if (s_awready !== 1'b0 || s_wready !== 1'b0 || s_arready !== 1'b0) begin
      errors++; $display("FAIL reset_readys: aw=%b w=%b ar=%b required 0 0 0", s_awready, s_wready, s_arready); end
    checks++; if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0 || ram_wen !== 1'b0 || ram_rflag !== 1'b0) begin
      errors++; $display("FAIL reset_valids: b=%b r=%b wen=%b rflag=%b required 0", s_bvalid, s_rvalid, ram_wen, ram_rflag); end
    checks++; if (ram_raddr !== 64'd0 || ram_waddr !== 64'd0 || ram_wdata !== 64'd0 || ram_wmask !== 64'd0) begin
      errors++; $display("FAIL reset_ram_bus: raddr=%h waddr=%h wdata=%h wmask=%h required 0", ram_raddr, ram_waddr, ram_wdata, ram_wmask); end
    checks++; if (s_rdata !== 64'd0 || s_bresp !== 2'b00 || s_rresp !== 2'b00) begin
      errors++; $display("FAIL reset_resp: rdata=%h bresp=%b rresp=%b required 0", s_rdata, s_bresp, s_rresp); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    checks++; if (s_awready !== 1'b1 || s_wready !== 1'b1 || s_arready !== 1'b1) begin
      errors++; $display("FAIL release_readys: aw=%b w=%b ar=%b required 1 1 1", s_awready, s_wready, s_arready); end
    checks++; if (dbg_state !== 3'd0) begin
      errors++; $display("FAIL release_state: got %0d required 0", dbg_state); end
    @(posedge clock); #1;
  endtask

  task automatic test_single_read;
    int rf0;
    bit ok;
    rf0 = rflag_cnt;
    s_araddr = 32'h8000_0008; s_arvalid = 1'b1;
    #1;
    checks++; if (s_arready !== 1'b1) begin
      errors++; $display("FAIL rd_arready: got %b required 1", s_arready); end
    @(posedge clock); #1;
    s_arvalid = 1'b0;
    checks++; if (ram_rflag !== 1'b1 || ram_raddr !== 64'h8000_0008 || s_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_rflag_n1: rflag=%b raddr=%h rvalid=%b required 1 80000008 0", ram_rflag, ram_raddr, s_rvalid); end
    @(posedge clock); #1;
    checks++; if (ram_rflag !== 1'b0 || s_rvalid !== 1'b1 || s_rdata !== 64'h1122_3344_5566_7788) begin
      errors++; $display("FAIL rd_rvalid_n2: rflag=%b rvalid=%b rdata=%h required 0 1 1122334455667788", ram_rflag, s_rvalid, s_rdata); end
    ok = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      if (s_rvalid !== 1'b1 || s_rdata !== 64'h1122_3344_5566_7788 || ram_rflag !== 1'b0) ok = 1'b0;
    end
    checks++; if (!ok) begin
      errors++; $display("FAIL rd_stall_stable: rvalid=%b rdata=%h required stable 1 1122334455667788", s_rvalid, s_rdata); end
    s_rready = 1'b1;
    @(posedge clock); #1;
    s_rready = 1'b0;
    checks++; if (s_rvalid !== 1'b0 || s_rresp !== 2'b00) begin
      errors++; $display("FAIL rd_done: rvalid=%b rresp=%b required 0 00", s_rvalid, s_rresp); end
    checks++; if (ram_raddr !== 64'h8000_0008) begin
      errors++; $display("FAIL rd_raddr_hold: got %h required 80000008", ram_raddr); end
    checks++; if (rflag_cnt - rf0 !== 1) begin
      errors++; $display("FAIL rd_rflag_count: got %0d required 1", rflag_cnt - rf0); end
  endtask

  task automatic test_write_w_first;
    int w0;
    w0 = wen_cnt;
    s_wdata = 64'hDEAD_BEEF_CAFE_F00D; s_wstrb = 8'h0F; s_wvalid = 1'b1;
    #1;
    checks++; if (s_wready !== 1'b1 || s_arready !== 1'b0) begin
      errors++; $display("FAIL wr_wready: wready=%b arready=%b required 1 0", s_wready, s_arready); end
    @(posedge clock); #1;
    s_wvalid = 1'b0;
    checks++; if (s_wready !== 1'b0 || s_awready !== 1'b1 || ram_wen !== 1'b0) begin
      errors++; $display("FAIL wr_w_held: wready=%b awready=%b wen=%b required 0 1 0", s_wready, s_awready, ram_wen); end
    @(posedge clock); #1;
    s_awaddr = 32'h8000_0010; s_awvalid = 1'b1;
    #1;
    checks++; if (s_awready !== 1'b1) begin
      errors++; $display("FAIL wr_awready: got %b required 1", s_awready); end
    @(posedge clock); #1;
    s_awvalid = 1'b0;
    checks++; if (ram_wen !== 1'b1 || ram_waddr !== 64'h8000_0010 || ram_wmask !== 64'h0000_0000_FFFF_FFFF
                  || ram_wdata !== 64'hDEAD_BEEF_CAFE_F00D) begin
      errors++; $display("FAIL wr_wen_n1: wen=%b waddr=%h wmask=%h wdata=%h required 1 80000010 00000000ffffffff deadbeefcafef00d",
                         ram_wen, ram_waddr, ram_wmask, ram_wdata); end
    @(posedge clock); #1;
    checks++; if (ram_wen !== 1'b0 || s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
      errors++; $display("FAIL wr_bvalid_n2: wen=%b bvalid=%b bresp=%b required 0 1 00", ram_wen, s_bvalid, s_bresp); end
    s_bready = 1'b1;
    @(posedge clock); #1;
    s_bready = 1'b0;
    checks++; if (s_bvalid !== 1'b0 || wen_cnt - w0 !== 1) begin
      errors++; $display("FAIL wr_done: bvalid=%b wen_pulses=%0d required 0 1", s_bvalid, wen_cnt - w0); end
    ref_mem[2] = {ref_mem[2][63:32], 32'hCAFE_F00D};
  endtask

  task automatic test_simultaneous;
    s_araddr = 32'h8000_0018; s_arvalid = 1'b1;
    s_awaddr = 32'h8000_0018; s_awvalid = 1'b1;
    s_wdata = 64'hA5A5_A5A5_5A5A_5A5A; s_wstrb = 8'hFF; s_wvalid = 1'b1;
    #1;
    checks++; if (s_arready !== 1'b0 || s_awready !== 1'b1 || s_wready !== 1'b1) begin
      errors++; $display("FAIL sim_readys: ar=%b aw=%b w=%b required 0 1 1", s_arready, s_awready, s_wready); end
    @(posedge clock); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    checks++; if (ram_wen !== 1'b1 || ram_rflag !== 1'b0 || s_arready !== 1'b0) begin
      errors++; $display("FAIL sim_write_first: wen=%b rflag=%b arready=%b required 1 0 0", ram_wen, ram_rflag, s_arready); end
    @(posedge clock); #1;
    checks++; if (s_bvalid !== 1'b1 || s_arready !== 1'b0) begin
      errors++; $display("FAIL sim_b: bvalid=%b arready=%b required 1 0", s_bvalid, s_arready); end
    s_bready = 1'b1;
    @(posedge clock); #1;
    s_bready = 1'b0;
    checks++; if (s_bvalid !== 1'b0 || s_arready !== 1'b1) begin
      errors++; $display("FAIL sim_ar_after_b: bvalid=%b arready=%b required 0 1", s_bvalid, s_arready); end
    @(posedge clock); #1;
    s_arvalid = 1'b0;
    checks++; if (ram_rflag !== 1'b1 || ram_raddr !== 64'h8000_0018) begin
      errors++; $display("FAIL sim_rflag: rflag=%b raddr=%h required 1 80000018", ram_rflag, ram_raddr); end
    @(posedge clock); #1;
    checks++; if (s_rvalid !== 1'b1 || s_rdata !== 64'hA5A5_A5A5_5A5A_5A5A) begin
      errors++; $display("FAIL sim_rdata: rvalid=%b rdata=%h required 1 a5a5a5a55a5a5a5a", s_rvalid, s_rdata); end
    s_rready = 1'b1;
    @(posedge clock); #1;
    s_rready = 1'b0;
    ref_mem[3] = 64'hA5A5_A5A5_5A5A_5A5A;
  endtask

  task automatic test_unaligned;
    s_araddr = 32'h8000_0013; s_arvalid = 1'b1;
    @(posedge clock); #1;
    s_arvalid = 1'b0;
    checks++; if (ram_rflag !== 1'b1 || ram_raddr !== 64'h8000_0010) begin
      errors++; $display("FAIL unal_align1: rflag=%b raddr=%h required 1 80000010", ram_rflag, ram_raddr); end
    checks++; if (a0_rflag !== 1'b1 || a0_raddr !== 64'h8000_0013) begin
      errors++; $display("FAIL unal_align0: rflag=%b raddr=%h required 1 80000013", a0_rflag, a0_raddr); end
    @(posedge clock); #1;
    checks++; if (s_rdata !== ref_mem[2] || a0_rdata !== ref_mem[2]) begin
      errors++; $display("FAIL unal_rdata: align1=%h align0=%h required %h", s_rdata, a0_rdata, ref_mem[2]); end
    s_rready = 1'b1;
    @(posedge clock); #1;
    s_rready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int rf0;
    bit seen;
    bit to;
    logic [63:0] d;
    s_araddr = 32'h8000_0008; s_arvalid = 1'b1;
    @(posedge clock); #1;
    s_arvalid = 1'b0;
    @(posedge clock); #1;
    checks++; if (s_rvalid !== 1'b1) begin
      errors++; $display("FAIL rstmid_rvalid_before: got %b required 1", s_rvalid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (s_rvalid !== 1'b0 || s_arready !== 1'b0 || s_rdata !== 64'd0 || ram_raddr !== 64'd0) begin
      errors++; $display("FAIL rstmid_async: rvalid=%b arready=%b rdata=%h raddr=%h required 0 0 0 0",
                         s_rvalid, s_arready, s_rdata, ram_raddr); end
    rf0 = rflag_cnt;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    s_rready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      if (s_rvalid !== 1'b0 || ram_rflag !== 1'b0) seen = 1'b1;
    end
    s_rready = 1'b0;
    checks++; if (seen || rflag_cnt != rf0) begin
      errors++; $display("FAIL rstmid_no_beat: stray_beat=%b rflag_pulses=%0d required 0 0", seen, rflag_cnt - rf0); end
    drv_read(32'h8000_0008, d, to);
    checks++; if (to || d !== ref_mem[1]) begin
      errors++; $display("FAIL rstmid_new_read: timeout=%b data=%h required 0 %h", to, d, ref_mem[1]); end
  endtask

  task automatic test_back_to_back;
    int w0, rf0, nw, nr;
    bit to;
    int idx;
    logic [31:0] a;
    logic [63:0] d, m, got, exp;
    logic [7:0]  s;
    w0 = wen_cnt; rf0 = rflag_cnt; nw = 0; nr = 0;
    for (int t = 0; t < 16; t++) begin
      idx = $urandom_range(0, 31);
      a   = 32'h8000_0000 + 32'(idx * 8) + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        s = 8'($urandom_range(1, 255));
        m = '0;
        for (int b = 0; b < 8; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
        ref_mem[idx] = (ref_mem[idx] & ~m) | (d & m);
        drv_write(a, d, s, to);
        nw++;
        checks++; if (to) begin
          errors++; $display("FAIL b2b_write_timeout: op=%0d addr=%h", t, a); end
      end else begin
        exp_q.push_back(ref_mem[idx]);
        drv_read(a, got, to);
        nr++;
        exp = exp_q.pop_front();
        checks++; if (to || got !== exp) begin
          errors++; $display("FAIL b2b_read: op=%0d addr=%h timeout=%b got %h required %h", t, a, to, got, exp); end
      end
    end
    checks++; if (wen_cnt - w0 !== nw || rflag_cnt - rf0 !== nr) begin
      errors++; $display("FAIL b2b_pulses: wen=%0d rflag=%0d required %0d %0d", wen_cnt - w0, rflag_cnt - rf0, nw, nr); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    errors = 0; checks = 0; wen_cnt = 0; rflag_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = {32'hC0DE_0000 + 32'(i), 32'h1357_0000 + 32'(i * 3)};
      ref_mem[i] = {32'hC0DE_0000 + 32'(i), 32'h1357_0000 + 32'(i * 3)};
    end
    mem[1]     = 64'h1122_3344_5566_7788;
    ref_mem[1] = 64'h1122_3344_5566_7788;
    reset_n = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_single_read();
    test_write_w_first();
    test_simultaneous();
    test_unaligned();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_ram_bridge.md
Name: axi_lite_ram_bridge

Overview:
- AXI4-Lite slave (64-bit data) sitting directly upstream of the DPI-backed RAM controller (RAMCtrl).
- Converts AR/R and AW/W/B channel handshakes into single-cycle, stable access strobes on RAMCtrl's raddr/rdata/rflag/waddr/wdata/wmask/wen ports.
- Serialises accesses: one transaction in flight; write has priority over read.
- Holds RAM-side address/data stable outside access cycles, so the combinational DPI call never sees a spurious strobe.

Parameters:
ADDR_WIDTH, 32, AXI address width; zero-extended to 64 bits on the RAM side.
ALIGN, 1, 1 = clear addr[2:0] before driving raddr/waddr; 0 = pass the address through unchanged.

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
s_awaddr  input  ADDR_WIDTH  write address
s_awvalid  input  1  AW valid
s_awready  output  1  AW ready
s_wdata  input  64  write data
s_wstrb  input  8  byte strobes
s_wvalid  input  1  W valid
s_wready  output  1  W ready
s_bresp  output  2  write response (always 2'b00)
s_bvalid  output  1  B valid
s_bready  input  1  B ready
s_araddr  input  ADDR_WIDTH  read address
s_arvalid  input  1  AR valid
s_arready  output  1  AR ready
s_rdata  output  64  read data (registered)
s_rresp  output  2  read response (always 2'b00)
s_rvalid  output  1  R valid
s_rready  input  1  R ready
ram_raddr  output  64  to RAMCtrl raddr
ram_rdata  input  64  from RAMCtrl rdata (combinational)
ram_rflag  output  1  to RAMCtrl rflag; one-cycle pulse per read
ram_waddr  output  64  to RAMCtrl waddr
ram_wdata  output  64  to RAMCtrl wdata
ram_wmask  output  64  to RAMCtrl wmask (bit mask)
ram_wen  output  1  to RAMCtrl wen; one-cycle pulse per write

Behaviour:
- FSM states: IDLE, WR_ACC, WR_RESP, RD_ACC, RD_RESP.
- Flags aw_held and w_held record channels already accepted. Registers: addr_q, wdata_q, wstrb_q, rdata_q.

Ready and accept rules (in IDLE):
- s_awready = IDLE & !aw_held.
- s_wready = IDLE & !w_held.
- s_arready = IDLE & !aw_held & !w_held & !s_awvalid & !s_wvalid, so a pending or arriving write blocks reads.
- AW and W may arrive in any order or in the same cycle. Each is latched on its handshake.

IDLE transitions:
- If (aw_held or AW handshake this cycle) and (w_held or W handshake this cycle), go to WR_ACC.
- Else on AR handshake, latch addr_q and go to RD_ACC.

Write path:
- WR_ACC: ram_wen=1 for exactly this cycle; ram_waddr/ram_wdata/ram_wmask driven from registers.
- ram_wmask byte i = {8{wstrb_q[i]}}.
- Next state WR_RESP; clear aw_held and w_held.
- WR_RESP: s_bvalid=1 and held until s_bready; then go to IDLE (s_bvalid=0 next cycle).

Read path:
- RD_ACC: ram_rflag=1 for exactly this cycle; ram_raddr = addr_q.
- rdata_q <= ram_rdata at the end of this cycle. Next state RD_RESP.
- RD_RESP: s_rvalid=1, s_rdata=rdata_q, both stable until s_rready; then go to IDLE.

Latency:
- Read: AR handshake in cycle N → ram_rflag in N+1 → s_rvalid in N+2.
- Write: last of AW/W handshake in N → ram_wen in N+1 → s_bvalid in N+2.
- Back-to-back: the earliest next accept is the cycle after the B/R handshake.

Address:
- {zeros, addr_q} with [2:0] forced to 0 when ALIGN=1.
- ram_raddr and ram_waddr hold their last value outside access cycles; they are never X after reset.

Idle outputs:
- ram_wen=0 and ram_rflag=0 in every state except WR_ACC and RD_ACC respectively.

Reset (reset_n low, asynchronous, including mid-transaction):
- State → IDLE; aw_held=w_held=0.
- All valids and readys low while reset_n is low.
- ram_wen=0, ram_rflag=0; ram_raddr=ram_waddr=0, ram_wdata=0, ram_wmask=0.
- s_rdata=0, bresp/rresp=0.
- In-flight transactions are dropped, with no response issued after reset.
- After release, s_awready and s_wready go to 1 on the first IDLE cycle. s_arready goes to 1 on that cycle only if AW/W are not asserted.

Test Plan:
- Single read: s_araddr=0x80000008, ram_rdata model returns 0x1122334455667788 → ram_rflag pulses once at N+1 with ram_raddr=0x80000008; s_rvalid at N+2 with s_rdata=0x1122334455667788; s_rready held low 3 cycles → data and valid stable throughout.
- Write, W before AW: s_wdata=0xDEADBEEFCAFEF00D, s_wstrb=0x0F; AW(0x80000010) 2 cycles later → exactly one ram_wen pulse with ram_wmask=0x00000000FFFFFFFF and ram_waddr=0x80000010; s_bvalid 2 cycles after AW; bresp=0.
- Simultaneous AR, AW and W in one cycle → s_arready=0; write completes first (wen, then B); AR is accepted in the cycle after the B handshake, and the read returns the newly written data.
- Unaligned 0x80000013 with ALIGN=1 → ram_raddr=0x80000010; with ALIGN=0 → ram_raddr=0x80000013.
- Reset asserted in RD_RESP with s_rvalid=1 → s_rvalid=0 immediately (asynchronous); after release no R beat appears; a new read completes normally.
- Back-to-back 16 random reads and writes against a reference memory, with random ready stalls → data matches; one rflag per read; one wen per write; zero extra pulses.
